// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - pixel, fade-control and VGA signal bundle for sprite_compositor
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4,
    parameter int OUT_W      = 8,
    parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
);
    logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]           layer_en;
    logic [3*COLOR_W-1:0]            bg_rgb;
    logic                            blank_n;
    logic                            frame_start;
    logic                            fade_out_req;
    logic                            fade_in_req;
    logic [OUT_W-1:0]                VGA_R;
    logic [OUT_W-1:0]                VGA_G;
    logic [OUT_W-1:0]                VGA_B;
    logic [LW-1:0]                   top_layer;
    logic                            top_valid;
    logic                            fade_busy;
    logic [COLOR_W:0]                brightness;

    modport master (
        output layer_rgb, layer_en, bg_rgb, blank_n, frame_start, fade_out_req, fade_in_req,
        input  VGA_R, VGA_G, VGA_B, top_layer, top_valid, fade_busy, brightness
    );

    modport slave (
        input  layer_rgb, layer_en, bg_rgb, blank_n, frame_start, fade_out_req, fade_in_req,
        output VGA_R, VGA_G, VGA_B, top_layer, top_valid, fade_busy, brightness
    );
endinterface

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - priority sprite compositor with black-key transparency and frame-synchronous fade
module sprite_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4,
    parameter int OUT_W      = 8,
    parameter int FADE_DIV   = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    sprite_compositor_if.slave bus
);
    localparam int LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int BW   = COLOR_W + 1;
    localparam int PW   = 2*COLOR_W + 1;
    localparam int DW   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int PXW  = 3*COLOR_W;
    localparam logic [BW-1:0] BMAX = BW'(1 << COLOR_W);

    typedef enum logic [1:0] {IDLE, FADE_OUT, BLACK, FADE_IN} fade_state_t;

    fade_state_t state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    logic [DW-1:0] div_q, div_d;
    logic          busy_q;

    logic [NUM_LAYERS*PXW-1:0] s1_rgb;
    logic [PXW-1:0]            s1_bg;
    logic                      s1_blank_n;
    logic [NUM_LAYERS-1:0]     s1_opaque;
    logic [NUM_LAYERS-1:0]     opaque;

    logic          win;
    logic [LW-1:0] win_idx;
    logic [PXW-1:0] win_rgb;

    // Black (all-zero) is the transparency key.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque[i] = bus.layer_en[i] && (|bus.layer_rgb[i*PXW +: PXW]);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_rgb     <= '0;
            s1_bg      <= '0;
            s1_blank_n <= 1'b0;
            s1_opaque  <= '0;
        end else begin
            s1_rgb     <= bus.layer_rgb;
            s1_bg      <= bus.bg_rgb;
            s1_blank_n <= bus.blank_n;
            s1_opaque  <= opaque;
        end
    end

    // Scan from the lowest priority upward so the lowest opaque index is the last assignment.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        win_rgb = s1_bg;
        for (int i = NUM_LAYERS-1; i >= 0; i--) begin
            if (s1_opaque[i]) begin
                win     = 1'b1;
                win_idx = LW'(i);
                win_rgb = s1_rgb[i*PXW +: PXW];
            end
        end
    end

    function automatic logic [OUT_W-1:0] scale(input logic [COLOR_W-1:0] c, input logic [BW-1:0] b);
        logic [PW-1:0] p;
        p = PW'(c) * PW'(b);
        return OUT_W'(p[COLOR_W +: COLOR_W]) << (OUT_W - COLOR_W);
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.VGA_R     <= '0;
            bus.VGA_G     <= '0;
            bus.VGA_B     <= '0;
            bus.top_layer <= '0;
            bus.top_valid <= 1'b0;
        end else if (!s1_blank_n) begin
            bus.VGA_R     <= '0;
            bus.VGA_G     <= '0;
            bus.VGA_B     <= '0;
            bus.top_layer <= '0;
            bus.top_valid <= 1'b0;
        end else begin
            bus.VGA_R     <= scale(win_rgb[2*COLOR_W +: COLOR_W], b_q);
            bus.VGA_G     <= scale(win_rgb[COLOR_W +: COLOR_W], b_q);
            bus.VGA_B     <= scale(win_rgb[0 +: COLOR_W], b_q);
            bus.top_layer <= win_idx;
            bus.top_valid <= win;
        end
    end

    // A state-changing request consumes its cycle: divider cleared, no brightness step.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (bus.fade_out_req) begin
                    state_d = FADE_OUT;
                    div_d   = '0;
                end
            end
            FADE_OUT: begin
                if (bus.fade_in_req && !bus.fade_out_req) begin
                    state_d = FADE_IN;
                    div_d   = '0;
                end else if (b_q == '0) begin
                    state_d = BLACK;
                end else if (bus.frame_start) begin
                    if (div_q == DW'(FADE_DIV-1)) begin
                        div_d = '0;
                        b_d   = b_q - 1'b1;
                        if (b_q == BW'(1)) state_d = BLACK;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            BLACK: begin
                if (bus.fade_in_req && !bus.fade_out_req) begin
                    state_d = FADE_IN;
                    div_d   = '0;
                end
            end
            FADE_IN: begin
                if (bus.fade_out_req) begin
                    state_d = FADE_OUT;
                    div_d   = '0;
                end else if (b_q == BMAX) begin
                    state_d = IDLE;
                end else if (bus.frame_start) begin
                    if (div_q == DW'(FADE_DIV-1)) begin
                        div_d = '0;
                        b_d   = b_q + 1'b1;
                        if (b_q == BMAX - 1'b1) state_d = IDLE;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            b_q     <= BMAX;
            div_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            div_q   <= div_d;
            busy_q  <= (state_d == FADE_OUT) || (state_d == FADE_IN);
        end
    end

    assign bus.fade_busy  = busy_q;
    assign bus.brightness = b_q;
endmodule
